// File: rtl/axi_wr_slave.sv
// AXI write-channel slave that turns AW/W bursts into native single-beat
// memory writes and answers each burst with one B response.
// Bursts are incrementing only: each accepted beat advances the address by
// one beat width. A burst always lasts exactly awlen+1 beats. A wlast that
// arrives early or late does not end the burst; it only flags SLVERR.

`ifndef ROW_BITS
`define ROW_BITS 13
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef DQ_BITS
`define DQ_BITS 16
`endif

module axi_wr_slave #(
  parameter int ADDR_WIDTH = `ROW_BITS + `COL_BITS + `BA_BITS,
  parameter int DATA_WIDTH = `DQ_BITS * 2,
  parameter int DATA_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  // One beat's worth of bytes; the address adder truncates, so it wraps.
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(1 << DATA_LEVEL);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic beat_fire;
  logic last_beat;

  // State and burst registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Beat bookkeeping: a beat completes only while in DATA with both sides ready.
  always_comb begin
    beat_fire = (state_q == DATA) && wvalid && mem_wready;
    last_beat = (cnt_q == len_q);
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    awready    = 1'b0;
    wready     = 1'b0;
    mem_wvalid = 1'b0;
    bvalid     = 1'b0;
    bresp      = 2'b00;

    case (state_q)
      IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          addr_d  = awaddr;
          len_d   = awlen;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        wready     = mem_wready;
        mem_wvalid = wvalid;
        if (beat_fire) begin
          addr_d = addr_q + BEAT_STEP;
          cnt_d  = cnt_q + 8'd1;
          // wlast must appear on, and only on, the beat the length predicts.
          if (wlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (bready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Native port passes data straight through at the current beat address.
  always_comb begin
    mem_waddr = addr_q;
    mem_wdata = wdata;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed scenarios plus randomized
// bursts, compared against a burst-level reference model.
module tb_axi_wr_slave;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DL    = 2;
  localparam int BYTES = 1 << DL;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic          wlast = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [1:0]    bresp;
  logic          mem_wvalid;
  logic          mem_wready = 1'b0;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          busy;

  int errors = 0;
  int checks = 0;

  axi_wr_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DATA_LEVEL(DL)
  ) dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Wait until one time unit after the next rising edge (input drive point).
  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  // One full burst. early: -1 wlast on the final beat, -2 never, k>=0 only on beat k.
  // stall: 0 always ready, 1 mem_wready alternating 1,0,1..., 2 random valid/ready.
  task automatic do_burst(input logic [AW-1:0] a, input int len, input int early,
                          input int stall, input int bready_delay);
    logic [AW-1:0] exp_addr [$];
    logic          exp_wlast [$];
    logic          exp_err;
    logic [1:0]    exp_resp;
    int            i;
    int            cyc;

    // Reference model: whole-burst expectations from plain arithmetic.
    exp_err = 1'b0;
    for (int k = 0; k <= len; k++) begin
      logic wl;
      exp_addr.push_back(AW'(32'(a) + 32'(k) * BYTES));
      if (early == -1)      wl = (k == len);
      else if (early == -2) wl = 1'b0;
      else                  wl = (k == early);
      exp_wlast.push_back(wl);
      if (wl != (k == len)) exp_err = 1'b1;
    end
    exp_resp = exp_err ? 2'b10 : 2'b00;

    // Address phase.
    awvalid = 1'b1;
    awaddr  = a;
    awlen   = 8'(len);
    @(negedge clk);
    check_val("aw_awready", awready, 1'b1);
    next_drive();
    awvalid = 1'b0;
    awaddr  = '0;

    // Data phase.
    i   = 0;
    cyc = 0;
    while (i <= len) begin
      if (cyc > 4000) begin
        check_val("beat_timeout", 1'b1, 1'b0);
        break;
      end
      case (stall)
        0:       begin wvalid = 1'b1; mem_wready = 1'b1; end
        1:       begin wvalid = 1'b1; mem_wready = (cyc % 2 == 0); end
        default: begin wvalid = ($urandom_range(3) != 0); mem_wready = ($urandom_range(2) != 0); end
      endcase
      wdata = $urandom;
      wlast = exp_wlast[i];
      @(negedge clk);
      check_val("data_wready", wready, mem_wready);
      check_val("data_mem_wvalid", mem_wvalid, wvalid);
      check_val("data_bvalid", bvalid, 1'b0);
      check_val("data_busy", busy, 1'b1);
      if (wvalid && mem_wready) begin
        check_val("mem_waddr", mem_waddr, exp_addr[i]);
        check_val("mem_wdata", mem_wdata, wdata);
        i++;
      end
      cyc++;
      next_drive();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    mem_wready = 1'b0;
    if (stall == 0) check_val("beat_cycles", cyc, len + 1);

    // Response phase.
    for (int d = 0; d < bready_delay; d++) begin
      @(negedge clk);
      check_val("resp_bvalid_hold", bvalid, 1'b1);
      check_val("resp_bresp_hold", bresp, exp_resp);
      check_val("resp_awready", awready, 1'b0);
      next_drive();
    end
    bready = 1'b1;
    @(negedge clk);
    check_val("resp_bvalid", bvalid, 1'b1);
    check_val("resp_bresp", bresp, exp_resp);
    check_val("resp_exit_awready", awready, 1'b0);
    next_drive();
    bready = 1'b0;
    @(negedge clk);
    check_val("idle_bvalid", bvalid, 1'b0);
    check_val("idle_bresp", bresp, 2'b00);
    check_val("idle_awready", awready, 1'b1);
    check_val("idle_busy", busy, 1'b0);
    next_drive();
    $display("burst addr=%0h len=%0d early=%0d stall=%0d resp=%0b cycles=%0d",
             a, len, early, stall, exp_resp, cyc);
  endtask

  initial begin
    // Reset state, checked while rstn is still low.
    #2;
    check_val("rst_awready", awready, 1'b1);
    check_val("rst_wready", wready, 1'b0);
    check_val("rst_bvalid", bvalid, 1'b0);
    check_val("rst_bresp", bresp, 2'b00);
    check_val("rst_mem_wvalid", mem_wvalid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_mem_waddr", mem_waddr, '0);
    next_drive();
    next_drive();
    rstn = 1'b1;
    next_drive();

    // W channel ignored in IDLE.
    wvalid = 1'b1; mem_wready = 1'b1; wlast = 1'b1;
    @(negedge clk);
    check_val("idle_wready", wready, 1'b0);
    check_val("idle_mem_wvalid", mem_wvalid, 1'b0);
    next_drive();
    @(negedge clk);
    check_val("idle_stays", busy, 1'b0);
    next_drive();
    wvalid = 1'b0; mem_wready = 1'b0; wlast = 1'b0;

    // Directed scenarios.
    do_burst(16'h0000, 7, -1, 0, 0);
    do_burst(16'h0040, 0, -1, 0, 0);
    do_burst(16'h0080, 3, 1, 0, 1);
    do_burst(16'h00C0, 3, -2, 0, 0);
    do_burst(16'hFFFC, 1, -1, 1, 0);
    do_burst(16'hFF00, 255, -1, 0, 2);

    // Reset mid-burst after three beats of an awlen=7 burst.
    awvalid = 1'b1; awaddr = 16'h0200; awlen = 8'd7;
    next_drive();
    awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wvalid = 1'b1; mem_wready = 1'b1; wlast = 1'b0; wdata = $urandom;
      @(negedge clk);
      check_val("abort_mem_waddr", mem_waddr, AW'(16'h0200 + k * BYTES));
      next_drive();
    end
    rstn = 1'b0;
    #1;
    check_val("async_rst_busy", busy, 1'b0);
    check_val("async_rst_mem_wvalid", mem_wvalid, 1'b0);
    check_val("async_rst_wready", wready, 1'b0);
    check_val("async_rst_awready", awready, 1'b1);
    check_val("async_rst_mem_waddr", mem_waddr, '0);
    wvalid = 1'b0; mem_wready = 1'b0;
    next_drive();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abort_no_bvalid", bvalid, 1'b0);
      next_drive();
    end
    do_burst(16'h0100, 1, -1, 0, 5);

    // Randomized bursts.
    for (int r = 0; r < 12; r++) begin
      int len;
      int early;
      int sel;
      len = $urandom_range(15);
      sel = $urandom_range(3);
      if (sel <= 1)      early = -1;
      else if (sel == 2) early = -2;
      else               early = $urandom_range(len);
      do_burst(AW'($urandom), len, early, 2, $urandom_range(3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_wr_slave.md
AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows:
- ADDR_WIDTH, `ROW_BITS+`COL_BITS+`BA_BITS: byte-address width.
- DATA_WIDTH, `DQ_BITS*2: beat width.
- DATA_LEVEL, 2: log2 of bytes per beat.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows:
- clk, in, 1: clock.
- rstn, in, 1: reset, asynchronous, active-low.
- awvalid, in, 1: write address valid.
- awready, out, 1: write address ready.
- awaddr, in, ADDR_WIDTH: burst start address.
- awlen, in, 8: beats minus one.
- wvalid, in, 1: write data valid.
- wready, out, 1: write data ready.
- wlast, in, 1: final-beat marker from the master.
- wdata, in, DATA_WIDTH: write data.
- bvalid, out, 1: write response valid.
- bready, in, 1: write response accepted.
- bresp, out, 2: write response, 00 OKAY, 10 SLVERR.
- mem_wvalid, out, 1: native write strobe.
- mem_wready, in, 1: native port ready.
- mem_waddr, out, ADDR_WIDTH: native beat address.
- mem_wdata, out, DATA_WIDTH: native beat data.
- busy, out, 1: burst in progress, meaning state is not IDLE.

Function
REQ-003 The controller SHALL have three states, IDLE, DATA and RESP, with IDLE entered on reset.
REQ-004 awready SHALL equal 1 only in IDLE; bvalid SHALL equal 1 only in RESP.
REQ-005 An AW handshake (awvalid and awready high at clk edge) SHALL latch awaddr into the address register and awlen into the length register, clear the beat counter and error flag, and move to DATA on the next cycle.
REQ-006 In IDLE, W-channel inputs SHALL be ignored and wready SHALL be 0.
REQ-007 In DATA, wready SHALL equal mem_wready, combinationally.
REQ-008 In DATA, mem_wvalid SHALL equal wvalid, combinationally; it SHALL be 0 in all other states.
REQ-009 mem_wdata SHALL equal wdata and mem_waddr SHALL equal the address register, both combinationally.
REQ-010 A beat SHALL be accepted only when wvalid, wready and state DATA are all high at a clk edge.
REQ-011 On each accepted beat:
- address register += (1<<DATA_LEVEL), truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
- beat counter += 1; the counter is 8 bits.
REQ-012 The burst SHALL be the beat accepted when beat counter == length register; on that edge the state moves to RESP.
REQ-013 An accepted beat SHALL set the error flag when wlast=1 with counter != length, or when wlast=0 with counter == length.
REQ-014 After an early wlast the block SHALL keep accepting beats until counter == length; it SHALL NOT terminate the burst on wlast.
REQ-015 In RESP, bresp SHALL be 10 if the error flag is set and 00 otherwise; bresp SHALL be 00 outside RESP.
REQ-016 In RESP, bvalid SHALL hold high until bready=1 at a clk edge, then the state returns to IDLE.
REQ-017 With bready already high on RESP entry, bvalid SHALL last exactly one cycle.
REQ-018 awready SHALL NOT reassert in the RESP-exit cycle; the next AW can be accepted in the first IDLE cycle, giving minimum burst turnaround = len+1 DATA cycles + 1 RESP + 1 IDLE.
REQ-019 awlen=0 SHALL be a single-beat burst, and that beat SHALL carry wlast=1 for OKAY.
REQ-020 awlen=255 SHALL produce 256 beats with no counter overflow before termination.
REQ-021 mem_wready=0 SHALL stall DATA with all registers held; wvalid low likewise SHALL cause no state change.
REQ-022 busy SHALL be high in DATA and RESP.

Reset
REQ-023 While rstn=0, all of the following SHALL hold, asynchronously:
- state=IDLE; address, length, beat counter and error flag = 0.
- awready=1; wready=0; bvalid=0; bresp=00; mem_wvalid=0; busy=0.
REQ-024 rstn asserted mid-burst SHALL abandon the burst with no response; after release the block SHALL accept a fresh AW.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- awaddr=0x0, awlen=7, DATA_LEVEL=2, 8 beats with wlast on beat 7, mem_wready=1 -> mem_waddr 0x00,0x04,...,0x1C, one beat per cycle; bvalid with bresp=00; returns to IDLE after bready.
- awlen=0, single beat with wlast=1 -> one mem write; bresp=00.
- awlen=3, wlast on beat 1 -> 4 beats still written; bresp=10.
- awlen=3, wlast never asserted -> 4 beats written; bresp=10.
- awaddr=max-4, awlen=1 -> mem_waddr max-4, then 0; mem_wready toggling 1,0,1 -> wready mirrors mem_wready, no beat lost or duplicated.
- rstn pulsed low after beat 2 of awlen=7, then a new burst awaddr=0x100, awlen=1 -> no bvalid for the aborted burst; new burst writes 0x100 and 0x104; bresp=00; bready held low 5 cycles -> bvalid and bresp stable throughout.
